// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan sequencer.
// Build option: define ADC_SCAN_AVG_EN for 4-sample averaging per channel.
package adc_scan_pkg;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 12;
  localparam int AVG_CNT = 4;
  localparam int CH_W    = 3;
  localparam int ACC_W   = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_TRIG   = 3'd2,
    S_SETTLE = 3'd3,
    S_WAIT   = 3'd4,
    S_STORE  = 3'd5,
    S_GAP    = 3'd6
  } scan_state_e;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) first_ch = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/adc_scan_next_ch.sv
// Priority finder: next enabled channel strictly above cur_ch, plus a flag
// telling that cur_ch is the last enabled channel of the scan (no wrap).
module adc_scan_next_ch
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              last
);

  // Scan from the top down so the lowest qualifying bit wins.
  always_comb begin
    next_ch = cur_ch;
    last    = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_ch))) begin
        next_ch = CH_W'(i);
        last    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: walks the enabled channels of ch_mask, handshakes each
// conversion with the ADC driver (meas_start level / meas_done level) and
// keeps one result register plus a fresh flag per channel.
// Build option: ADC_SCAN_AVG_EN converts each channel 4 times and stores the
// mean (sum[13:2]); without it the raw sample is stored.
// Driver handshake: meas_ch is set on entry to ARM (meas_start low), meas_start
// goes high in TRIG and stays high until the next ARM; the driver drops
// meas_done on that rising edge and raises it with meas_data valid when done.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int SCAN_GAP    = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scan_en,
  input  logic              oneshot,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              meas_start,
  output logic [CH_W-1:0]   meas_ch,
  input  logic              meas_done,
  input  logic [DATA_W-1:0] meas_data,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic              rd_stb,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] valid,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err,
  output logic [2:0]        dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

  scan_state_e       state_q, state_d;
  logic [NUM_CH-1:0] scan_mask_q, scan_mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              meas_start_q, meas_start_d;
  logic              busy_q, busy_d;
  logic              scan_done_q, scan_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              scan_en_q;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] result_q [NUM_CH];
  logic [DATA_W-1:0] result_d [NUM_CH];
  logic [NUM_CH-1:0] valid_q, valid_d;
`ifdef ADC_SCAN_AVG_EN
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]        avg_cnt_q, avg_cnt_d;
  logic [ACC_W-1:0]  acc_sum;
`endif

  logic              chan_step;
  logic              start_scan;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_last;

  adc_scan_next_ch u_next_ch (
    .mask    (scan_mask_q),
    .cur_ch  (ch_q),
    .next_ch (nxt_ch),
    .last    (nxt_last)
  );

  // Next-state and datapath logic for the scan FSM.
  always_comb begin
    state_d       = state_q;
    scan_mask_d   = scan_mask_q;
    ch_d          = ch_q;
    meas_start_d  = meas_start_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    result_d      = result_q;
    valid_d       = valid_q;
    chan_step     = 1'b0;
    start_scan    = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    acc_d         = acc_q;
    avg_cnt_d     = avg_cnt_q;
    acc_sum       = acc_q + ACC_W'(meas_data);
`endif

    // A fresh request clears the sticky error; a timeout this cycle wins below.
    if (oneshot || (scan_en && !scan_en_q)) timeout_err_d = 1'b0;
    // Host read consumes the flag; a same-cycle store re-sets it below.
    if (rd_stb) valid_d[rd_ch] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_en || oneshot) start_scan = 1'b1;
      end
      S_ARM: begin
        meas_start_d = 1'b1;
        timer_d      = '0;
        state_d      = S_TRIG;
      end
      S_TRIG: begin
        timer_d = timer_q + 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        timer_d = timer_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (meas_done) begin
          state_d = S_STORE;
        end else if (timer_q >= TMR_W'(TIMEOUT_CYC)) begin
          timeout_err_d = 1'b1;
          chan_step     = 1'b1;
`ifdef ADC_SCAN_AVG_EN
          acc_d         = '0;
          avg_cnt_d     = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STORE: begin
`ifdef ADC_SCAN_AVG_EN
        if (avg_cnt_q == 2'(AVG_CNT - 1)) begin
          result_d[ch_q] = acc_sum[ACC_W-1:2];
          valid_d[ch_q]  = 1'b1;
          acc_d          = '0;
          avg_cnt_d      = '0;
          chan_step      = 1'b1;
        end else begin
          acc_d        = acc_sum;
          avg_cnt_d    = avg_cnt_q + 1'b1;
          meas_start_d = 1'b0;
          state_d      = S_ARM;
        end
`else
        result_d[ch_q] = meas_data;
        valid_d[ch_q]  = 1'b1;
        chan_step      = 1'b1;
`endif
      end
      S_GAP: begin
        if (!scan_en)          state_d    = S_IDLE;
        else if (gap_q == '0)  start_scan = 1'b1;
        else                   gap_d      = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Channel finished (stored or skipped): advance or close the scan.
    if (chan_step) begin
      if (!nxt_last) begin
        ch_d         = nxt_ch;
        meas_start_d = 1'b0;
        state_d      = S_ARM;
      end else begin
        scan_done_d = 1'b1;
        if (!scan_en)           state_d    = S_IDLE;
        else if (SCAN_GAP == 0) start_scan = 1'b1;
        else begin
          state_d = S_GAP;
          gap_d   = GAP_W'(SCAN_GAP - 1);
        end
      end
    end

    // The mask is captured only here, so mid-scan changes wait for the next scan.
    if (start_scan) begin
      if (ch_mask != '0) begin
        scan_mask_d  = ch_mask;
        ch_d         = first_ch(ch_mask);
        meas_start_d = 1'b0;
        state_d      = S_ARM;
      end else begin
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      scan_mask_q   <= '0;
      ch_q          <= '0;
      meas_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      scan_en_q     <= 1'b0;
      timer_q       <= '0;
      gap_q         <= '0;
      result_q      <= '{default: '0};
      valid_q       <= '0;
`ifdef ADC_SCAN_AVG_EN
      acc_q         <= '0;
      avg_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      scan_mask_q   <= scan_mask_d;
      ch_q          <= ch_d;
      meas_start_q  <= meas_start_d;
      busy_q        <= busy_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
      scan_en_q     <= scan_en;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      result_q      <= result_d;
      valid_q       <= valid_d;
`ifdef ADC_SCAN_AVG_EN
      acc_q         <= acc_d;
      avg_cnt_q     <= avg_cnt_d;
`endif
    end
  end

  assign meas_start  = meas_start_q;
  assign meas_ch     = ch_q;
  assign busy        = busy_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = timeout_err_q;
  assign valid       = valid_q;
  assign rd_data     = result_q[rd_ch];
  assign dbg_state   = state_q;

endmodule
